// File: rtl/debounce_pkg.sv
// Shared types and width helper for the button debounce / press classifier.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD
    } press_state_t;

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter
    import debounce_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max = (count_q == W'(MAX));
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !at_max) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/debounce_press.sv
// Debounces a synchronized button level and classifies each press as
// short (pulse on release) or long (pulse once the hold time is reached).
module debounce_press
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic short_press,
    output logic long_press
);

    localparam int DEB_W  = cnt_w(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_w(LONG_CYCLES);

    logic              level_q;
    logic              level_d;
    logic              short_press_q;
    logic              long_press_q;
    press_state_t      state_q;

    logic [DEB_W-1:0]  deb_cnt;
    logic              deb_at_max;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_at_max;

    logic differ;
    logic toggle;
    logic rise;
    logic fall;
    logic reach;

    always_comb begin
        differ  = (in != level_q);
        toggle  = differ && (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
        rise    = toggle && !level_q;
        fall    = toggle && level_q;
        // Hold count becomes LONG_CYCLES on this edge; a same-edge fall wins.
        reach   = level_q && !fall && !hold_at_max &&
                  (hold_cnt == HOLD_W'(LONG_CYCLES - 1));
        level_d = level_q ^ toggle;
    end

    sat_counter #(
        .MAX (DEBOUNCE_CYCLES),
        .W   (DEB_W)
    ) u_deb_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (!differ || toggle),
        .en     (differ && !deb_at_max),
        .count  (deb_cnt),
        .at_max (deb_at_max)
    );

    sat_counter #(
        .MAX (LONG_CYCLES),
        .W   (HOLD_W)
    ) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (rise),
        .en     (level_q),
        .count  (hold_cnt),
        .at_max (hold_at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            short_press_q <= 1'b0;
            long_press_q  <= 1'b0;
        end else begin
            short_press_q <= 1'b0;
            long_press_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        short_press_q <= 1'b1;
                        state_q       <= IDLE;
                    end else if (reach) begin
                        long_press_q <= 1'b1;
                        state_q      <= LONG_HELD;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign level       = level_q;
    assign short_press = short_press_q;
    assign long_press  = long_press_q;

endmodule
